// File: rtl/ahb_pixel_slave_pkg.sv
// Shared encodings, register map and responder state type for the AHB pixel slave.
package ahb_pixel_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_DATA   = 8'h08;
  localparam logic [7:0] OFF_OVFCNT = 8'h0C;
  localparam logic [7:0] OFF_THRESH = 8'h10;

  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVF       = 2;
  localparam int STAT_LEVEL_LSB = 8;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_DATA,
    RS_WAIT,
    RS_ERR1,
    RS_ERR2
  } resp_state_t;

endpackage

// File: rtl/ahb_pixel_slave_if.sv
// AHB-Lite bus bundle between the MSS fabric master and the pixel slave.
interface ahb_pixel_slave_if #(
  parameter int ADDR_W = 8
) ();
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADYIN;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic              HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADYIN,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb_pixel_slave_sync_fifo.sv
// First-word fall-through synchronous FIFO; a push while full only lands if a pop frees a slot.
module sync_fifo #(
  parameter  int DEPTH  = 16,
  parameter  int DATA_W = 32,
  localparam int AW     = $clog2(DEPTH),
  localparam int LW     = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [LW-1:0]     level
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push & ~flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ahb_pixel_slave.sv
// AHB-Lite responder exposing CTRL/STATUS/THRESH/OVFCNT and a pop window onto the pixel FIFO.
module ahb_pixel_slave
  import ahb_pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 16,
  parameter int ADDR_W     = 8
) (
  input  logic                    FAB_CLK,
  input  logic                    SYSRESET,
  ahb_pixel_slave_if.slave        ahb,
  input  logic                    pix_valid,
  input  logic [31:0]             pix_data,
  output logic                    ctrl_enable,
  output logic                    irq
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  resp_state_t       state;
  logic [ADDR_W-1:0] addr_p1;
  logic              write_p1;
  logic [7:0]        wcnt;
  logic [7:0]        thresh;
  logic              ovf;
  logic [15:0]       ovfcnt;

  logic              accept;
  logic              addr_err;
  logic              in_dphase;
  logic              rd_fifo;
  logic              stall;
  logic              timeout;
  logic              reg_wr;
  logic              clear;
  logic              push_req;
  logic              fifo_pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LW-1:0]     level;
  logic [31:0]       fifo_head;
  logic [31:0]       status;

  sync_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(32)) u_fifo (
    .clk   (FAB_CLK),
    .rst   (SYSRESET),
    .push  (push_req),
    .pop   (fifo_pop),
    .flush (clear),
    .din   (pix_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign accept    = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADYIN;
  assign in_dphase = (state == RS_DATA) || (state == RS_WAIT);
  assign rd_fifo   = in_dphase & ~write_p1 & (addr_p1 == ADDR_W'(OFF_DATA));
  assign stall     = rd_fifo & fifo_empty;
  assign fifo_pop  = rd_fifo & ~fifo_empty;
  assign push_req  = pix_valid & ctrl_enable;
  // A push arriving on the last allowed wait cycle rescues the read.
  assign timeout   = stall & (wcnt == 8'(TIMEOUT - 1)) & ~push_req;
  assign reg_wr    = (state == RS_DATA) & write_p1;
  assign clear     = reg_wr & (addr_p1 == ADDR_W'(OFF_CTRL)) & ahb.HWDATA[1];
  assign drop      = push_req & fifo_full & ~fifo_pop & ~clear;

  assign ahb.HREADYOUT = ~((state == RS_ERR1) | stall);
  assign ahb.HRESP     = ((state == RS_ERR1) || (state == RS_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

  // Legality is fully known in the address phase.
  always_comb begin
    addr_err = 1'b0;
    case (ahb.HADDR)
      ADDR_W'(OFF_CTRL), ADDR_W'(OFF_THRESH):                   addr_err = 1'b0;
      ADDR_W'(OFF_STATUS), ADDR_W'(OFF_DATA), ADDR_W'(OFF_OVFCNT): addr_err = ahb.HWRITE;
      default:                                                  addr_err = 1'b1;
    endcase
    if (ahb.HSIZE != HSIZE_WORD) addr_err = 1'b1;
  end

  always_comb begin
    status                 = 32'(level) << STAT_LEVEL_LSB;
    status[STAT_EMPTY]     = fifo_empty;
    status[STAT_FULL]      = fifo_full;
    status[STAT_OVF]       = ovf;
    ahb.HRDATA             = '0;
    if (in_dphase & ~write_p1) begin
      case (addr_p1)
        ADDR_W'(OFF_CTRL):   ahb.HRDATA = {31'b0, ctrl_enable};
        ADDR_W'(OFF_STATUS): ahb.HRDATA = status;
        ADDR_W'(OFF_DATA):   ahb.HRDATA = fifo_empty ? '0 : fifo_head;
        ADDR_W'(OFF_OVFCNT): ahb.HRDATA = {16'b0, ovfcnt};
        ADDR_W'(OFF_THRESH): ahb.HRDATA = {24'b0, thresh};
        default:             ahb.HRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge FAB_CLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      state    <= RS_IDLE;
      addr_p1  <= '0;
      write_p1 <= 1'b0;
      wcnt     <= '0;
    end else if (state == RS_ERR1) begin
      state <= RS_ERR2;
    end else if (stall) begin
      if (timeout) begin
        state <= RS_ERR1;
      end else begin
        state <= RS_WAIT;
        wcnt  <= wcnt + 1'b1;
      end
    end else if (accept) begin
      addr_p1  <= ahb.HADDR;
      write_p1 <= ahb.HWRITE;
      wcnt     <= '0;
      state    <= addr_err ? RS_ERR1 : RS_DATA;
    end else begin
      state <= RS_IDLE;
    end
  end

  always_ff @(posedge FAB_CLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      ctrl_enable <= 1'b0;
      thresh      <= '0;
      ovf         <= 1'b0;
      ovfcnt      <= '0;
      irq         <= 1'b0;
    end else begin
      if (reg_wr && addr_p1 == ADDR_W'(OFF_CTRL))   ctrl_enable <= ahb.HWDATA[0];
      if (reg_wr && addr_p1 == ADDR_W'(OFF_THRESH)) thresh      <= ahb.HWDATA[7:0];
      if (clear) begin
        ovf    <= 1'b0;
        ovfcnt <= '0;
      end else if (drop) begin
        ovf <= 1'b1;
        if (ovfcnt != 16'hFFFF) ovfcnt <= ovfcnt + 1'b1;
      end
      irq <= ctrl_enable & (thresh != '0) & (9'(level) >= {1'b0, thresh});
    end
  end
endmodule

// File: tb/tb_ahb_pixel_slave.sv
// Directed bench for ahb_pixel_slave: register table plus wait, timeout, overflow, irq and reset sequences.
module tb_ahb_pixel_slave;
  import ahb_pixel_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [31:0] pix_data;
  logic        ctrl_enable;
  logic        irq;

  ahb_pixel_slave_if #(.ADDR_W(8)) bus ();
  assign bus.HREADYIN = bus.HREADYOUT;

  ahb_pixel_slave #(.FIFO_DEPTH(16), .TIMEOUT(16), .ADDR_W(8)) dut (
    .FAB_CLK     (clk),
    .SYSRESET    (rst),
    .ahb         (bus),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .ctrl_enable (ctrl_enable),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          op;
    logic        wr;
    logic [7:0]  addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_err;
    logic        exp_en;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] rd;
  int          waits;
  int          err1;
  logic        resp;
  logic        okt;

  function automatic vec_t X(logic wr, logic [7:0] a, logic [2:0] sz, logic [31:0] wd,
                             logic [31:0] exp_rd, logic err, logic en);
    vec_t v;
    v.op = 0; v.wr = wr; v.addr = a; v.sz = sz; v.wd = wd;
    v.exp_rd = exp_rd; v.chk_rd = ~wr & ~err; v.exp_err = err; v.exp_en = en;
    return v;
  endfunction

  function automatic vec_t P(logic [31:0] w, logic en);
    vec_t v;
    v = X(1'b0, 8'h00, 3'b010, w, 32'h0, 1'b0, en);
    v.op = 1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_data  = w;
    @(posedge clk);
    #1 pix_valid = 1'b0;
  endtask

  // push_at: data-phase cycle number (1-based) in which pix_valid is raised; 0 = none.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int push_at, input logic [31:0] push_word,
                      output logic [31:0] rdata, output int nwait, output int nerr1,
                      output logic fresp, output logic done);
    int cyc;
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HADDR = addr; bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = wr; bus.HSIZE = size;
    @(posedge clk);
    #1;
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWDATA = wdata;
    nwait = 0; nerr1 = 0; done = 1'b0; cyc = 0; rdata = '0; fresp = 1'b0;
    while (!done && cyc < 100) begin
      cyc++;
      if (cyc == push_at) begin
        pix_valid = 1'b1;
        pix_data  = push_word;
      end
      @(negedge clk);
      if (bus.HREADYOUT) begin
        done  = 1'b1;
        rdata = bus.HRDATA;
        fresp = bus.HRESP;
      end else if (bus.HRESP) nerr1++;
      else nwait++;
      @(posedge clk);
      #1 pix_valid = 1'b0;
    end
  endtask

  task automatic rd_reg(input string name, input logic [7:0] addr, input logic [31:0] exp);
    xfer(1'b0, addr, HSIZE_WORD, 32'h0, 0, 32'h0, rd, waits, err1, resp, okt);
    chk({name, "_term"}, okt, 1);
    chk({name, "_resp"}, resp, HRESP_OKAY);
    chk(name, rd, exp);
  endtask

  task automatic wr_reg(input string name, input logic [7:0] addr, input logic [31:0] wd);
    xfer(1'b1, addr, HSIZE_WORD, wd, 0, 32'h0, rd, waits, err1, resp, okt);
    chk({name, "_resp"}, resp, HRESP_OKAY);
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0;
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = HTRANS_IDLE;
    bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD; bus.HWDATA = '0;

    vecs.push_back(X(1'b0, OFF_STATUS, 3'b010, 32'h0, 32'h0000_0001, 1'b0, 1'b0));
    vecs.push_back(X(1'b1, OFF_CTRL,   3'b010, 32'h1, 32'h0,         1'b0, 1'b1));
    vecs.push_back(P(32'hA0, 1'b1));
    vecs.push_back(P(32'hA1, 1'b1));
    vecs.push_back(P(32'hA2, 1'b1));
    vecs.push_back(X(1'b0, OFF_STATUS, 3'b010, 32'h0, 32'h0000_0300, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_DATA,   3'b010, 32'h0, 32'h0000_00A0, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_DATA,   3'b010, 32'h0, 32'h0000_00A1, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_DATA,   3'b010, 32'h0, 32'h0000_00A2, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_STATUS, 3'b010, 32'h0, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_CTRL,   3'b010, 32'h0, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(X(1'b1, OFF_THRESH, 3'b010, 32'h5A, 32'h0,        1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_THRESH, 3'b010, 32'h0, 32'h0000_005A, 1'b0, 1'b1));
    vecs.push_back(X(1'b1, OFF_THRESH, 3'b010, 32'h0, 32'h0,         1'b0, 1'b1));
    vecs.push_back(X(1'b1, OFF_STATUS, 3'b010, 32'hFF, 32'h0,        1'b1, 1'b1));
    vecs.push_back(X(1'b1, OFF_CTRL,   3'b001, 32'h0, 32'h0,         1'b1, 1'b1));
    vecs.push_back(X(1'b0, 8'h20,      3'b010, 32'h0, 32'h0,         1'b1, 1'b1));
    vecs.push_back(X(1'b1, OFF_DATA,   3'b010, 32'h0, 32'h0,         1'b1, 1'b1));
    vecs.push_back(X(1'b1, OFF_OVFCNT, 3'b010, 32'h0, 32'h0,         1'b1, 1'b1));
    vecs.push_back(X(1'b0, 8'h02,      3'b010, 32'h0, 32'h0,         1'b1, 1'b1));
    vecs.push_back(X(1'b1, OFF_THRESH, 3'b011, 32'h77, 32'h0,        1'b1, 1'b1));
    vecs.push_back(X(1'b0, OFF_CTRL,   3'b010, 32'h0, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_STATUS, 3'b010, 32'h0, 32'h0000_0001, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_THRESH, 3'b010, 32'h0, 32'h0000_0000, 1'b0, 1'b1));
    vecs.push_back(X(1'b0, OFF_OVFCNT, 3'b010, 32'h0, 32'h0000_0000, 1'b0, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_hreadyout", bus.HREADYOUT, 1);
    chk("rst_hresp", bus.HRESP, 0);
    chk("rst_hrdata", bus.HRDATA, 0);
    chk("rst_enable", ctrl_enable, 0);
    chk("rst_irq", irq, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].op == 1) begin
        push(vecs[i].wd);
      end else begin
        xfer(vecs[i].wr, vecs[i].addr, vecs[i].sz, vecs[i].wd, 0, 32'h0,
             rd, waits, err1, resp, okt);
        chk($sformatf("v%0d_term", i), okt, 1);
        chk($sformatf("v%0d_resp", i), resp, vecs[i].exp_err);
        chk($sformatf("v%0d_err1", i), err1, vecs[i].exp_err);
        chk($sformatf("v%0d_waits", i), waits, 0);
        if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      end
      chk($sformatf("v%0d_enable", i), ctrl_enable, vecs[i].exp_en);
    end

    // Empty DATA read rescued by a push in the fifth wait cycle.
    xfer(1'b0, OFF_DATA, HSIZE_WORD, 32'h0, 5, 32'h55, rd, waits, err1, resp, okt);
    chk("wait5_term", okt, 1);
    chk("wait5_waits", waits, 5);
    chk("wait5_err1", err1, 0);
    chk("wait5_resp", resp, HRESP_OKAY);
    chk("wait5_rdata", rd, 32'h55);

    // Empty DATA read with no push: TIMEOUT waits then a two-cycle ERROR.
    xfer(1'b0, OFF_DATA, HSIZE_WORD, 32'h0, 0, 32'h0, rd, waits, err1, resp, okt);
    chk("tmo_term", okt, 1);
    chk("tmo_waits", waits, 16);
    chk("tmo_err1", err1, 1);
    chk("tmo_resp", resp, HRESP_ERROR);

    // Push on the timeout cycle wins.
    xfer(1'b0, OFF_DATA, HSIZE_WORD, 32'h0, 16, 32'h66, rd, waits, err1, resp, okt);
    chk("tmowin_term", okt, 1);
    chk("tmowin_waits", waits, 16);
    chk("tmowin_err1", err1, 0);
    chk("tmowin_resp", resp, HRESP_OKAY);
    chk("tmowin_rdata", rd, 32'h66);
    rd_reg("tmowin_status", OFF_STATUS, 32'h0000_0001);

    // Overflow: 16 fill, 3 dropped, then a simultaneous push/pop while full.
    for (int i = 0; i < 16; i++) push(32'h100 + i);
    for (int i = 0; i < 3; i++) push(32'hDEAD_0000 + i);
    rd_reg("ovf_status", OFF_STATUS, 32'h0000_1006);
    rd_reg("ovf_cnt", OFF_OVFCNT, 32'h0000_0003);
    xfer(1'b0, OFF_DATA, HSIZE_WORD, 32'h0, 1, 32'h200, rd, waits, err1, resp, okt);
    chk("fullpp_rdata", rd, 32'h100);
    chk("fullpp_waits", waits, 0);
    rd_reg("fullpp_status", OFF_STATUS, 32'h0000_1006);
    rd_reg("fullpp_cnt", OFF_OVFCNT, 32'h0000_0003);
    rd_reg("fullpp_head", OFF_DATA, 32'h101);
    wr_reg("clr_wr", OFF_CTRL, 32'h3);
    rd_reg("clr_status", OFF_STATUS, 32'h0000_0001);
    rd_reg("clr_cnt", OFF_OVFCNT, 32'h0000_0000);
    rd_reg("clr_ctrl", OFF_CTRL, 32'h0000_0001);

    // Pushes with enable low are ignored.
    wr_reg("dis_wr", OFF_CTRL, 32'h0);
    push(32'h77);
    rd_reg("dis_status", OFF_STATUS, 32'h0000_0001);
    rd_reg("dis_cnt", OFF_OVFCNT, 32'h0000_0000);
    wr_reg("en_wr", OFF_CTRL, 32'h1);

    // Threshold interrupt.
    wr_reg("thr_wr", OFF_THRESH, 32'h4);
    for (int i = 1; i <= 3; i++) push(32'(i));
    @(posedge clk);
    #1 chk("irq_lvl3", irq, 0);
    push(32'h4);
    chk("irq_same_cycle", irq, 0);
    @(posedge clk);
    #1 chk("irq_lvl4", irq, 1);
    rd_reg("irq_pop", OFF_DATA, 32'h1);
    @(posedge clk);
    #1 chk("irq_after_pop", irq, 0);

    // Asynchronous reset in the middle of a wait state.
    wr_reg("pre_rst_clr", OFF_CTRL, 32'h2);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HADDR = OFF_DATA; bus.HTRANS = HTRANS_NONSEQ;
    bus.HWRITE = 1'b0; bus.HSIZE = HSIZE_WORD;
    @(posedge clk);
    #1;
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE;
    @(posedge clk);
    #1 chk("midwait_stall", bus.HREADYOUT, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_hreadyout", bus.HREADYOUT, 1);
    chk("arst_hresp", bus.HRESP, 0);
    chk("arst_hrdata", bus.HRDATA, 0);
    @(negedge clk);
    rst = 1'b0;
    rd_reg("post_rst_status", OFF_STATUS, 32'h0000_0001);
    rd_reg("post_rst_thresh", OFF_THRESH, 32'h0000_0000);
    chk("post_rst_enable", ctrl_enable, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/ahb_pixel_slave.md
Name: ahb_pixel_slave

Overview:
- AHB-Lite responder in the FPGA fabric, sitting on the MSS fabric master interface (MSSHADDR/MSSHTRANS/MSSHWRITE/MSSHSIZE/MSSHWDATA in; MSSHRDATA/MSSHREADY/MSSHRESP out).
- Gives the Cortex-M3 firmware a control/status register set and a read-pop window onto a word FIFO fed by the fabric pixel pipeline.
- Inserts wait states on empty-FIFO reads, bounded by a timeout, and returns ERROR responses for illegal accesses.

Parameters:
- FIFO_DEPTH, 16, FIFO entries of 32 bits; power of two, 4..256.
- TIMEOUT, 16, maximum wait-state cycles on an empty DATA read before ERROR; 1..255.
- ADDR_W, 8, number of HADDR bits decoded.

Ports:
- FAB_CLK  in  1  fabric clock; HCLK of the MSS fabric interface.
- SYSRESET  in  1  asynchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  byte address.
- HTRANS  in  2  transfer type.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYIN  in  1  bus-level HREADY.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  0 = insert wait state.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- pix_valid  in  1  push strobe from the pixel pipeline.
- pix_data  in  32  packed pixel word.
- ctrl_enable  out  1  CTRL.bit0; enables the pipeline and pushes.
- irq  out  1  level interrupt to the MSS.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, ctrl_enable=0, irq=0. FIFO is empty; overflow flag=0; OVFCNT=0; THRESH=0.
- Reset is asynchronous: asserting it mid-wait or mid-error forces HREADYOUT=1 and HRESP=0 immediately.
- Address phase is accepted when HSEL & HTRANS[1] & HREADYIN. The block latches address, write and size, and the data phase is the next cycle. IDLE and BUSY transfers get OKAY with zero wait states.
- Register map (word offsets):
  - 0x00 CTRL, RW: bit0 enable; bit1 clear, write-1, self-clearing, reads 0.
  - 0x04 STATUS, RO: bit0 empty; bit1 full; bit2 overflow (sticky); [15:8] level.
  - 0x08 DATA, RO: reading pops the FIFO.
  - 0x0C OVFCNT, RO: 16-bit saturating count of dropped words.
  - 0x10 THRESH, RW [7:0].
- ERROR conditions: unmapped offset, write to an RO register, HSIZE != 3'b010, or DATA read timeout.
- ERROR response is two cycles: cycle 1 HREADYOUT=0, HRESP=1; cycle 2 HREADYOUT=1, HRESP=1. A write that gets ERROR has no side effect.
- Zero-wait-state accesses: register writes take HWDATA in the data phase and the register updates at the end of that cycle. Register reads drive HRDATA in the data phase.
- DATA read, FIFO non-empty at data-phase start: HREADYOUT=1 in that cycle, HRDATA = FIFO head (first-word fall-through), pop at the end of the cycle.
- DATA read, FIFO empty: HREADYOUT=0 and a wait counter runs.
  - Complete in the first cycle the FIFO is non-empty.
  - If the counter reaches TIMEOUT with the FIFO still empty, start the ERROR sequence with no pop.
  - A push landing in the same cycle as the timeout wins: the read completes OKAY.
- Push rules:
  - A push occurs on pix_valid & ctrl_enable.
  - Pushes while enable=0 are ignored and not counted.
  - Push when full with no pop in the same cycle: the word is dropped, overflow is set, and OVFCNT increments, saturating at 0xFFFF.
  - Simultaneous push and pop when full is legal: no drop, level unchanged.
- CTRL clear flushes the FIFO and zeroes overflow and OVFCNT. It takes priority over a push in the same cycle.
- irq = ctrl_enable & (THRESH != 0) & (level >= THRESH), registered, so one cycle after the level change.
- Level width is clog2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[15:8].

Decomposition:
- Package ahb_pixel_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ) and HRESP encodings (OKAY, ERROR).
  - Register offset constants and STATUS bit positions.
  - The responder state enum: IDLE, DATA, WAIT, ERR1, ERR2.
- Sub-module sync_fifo: parameterised depth and width, first-word fall-through, with push, pop, flush, full, empty and level.

Test Plan:
- Reset, then read STATUS -> 0x00000001, OKAY, zero wait states; write CTRL=1 -> ctrl_enable=1 one cycle later.
- Push 3 words 0xA0..0xA2, then 3 DATA reads -> 0xA0, 0xA1, 0xA2 with HREADYOUT=1 each; then STATUS reads 0x00000001.
- DATA read on an empty FIFO, push 0x55 after 5 cycles -> 5 wait states, HRDATA=0x55, OKAY.
- DATA read on an empty FIFO with no push, TIMEOUT=16 -> 16 wait states, then a two-cycle ERROR (HREADYOUT 0→1, HRESP=1).
- Fill 16 words, push 3 more -> STATUS = 0x00001006 (full, overflow), OVFCNT = 3; write CTRL=3 -> STATUS = 0x00000001, OVFCNT = 0.
- Write STATUS, halfword access to CTRL, and read 0x20 -> each returns a two-cycle ERROR and all registers are unchanged; with THRESH=4, the 4th push raises irq and the next pop drops it.
